bfm_apbtoahb: RTL
=================

// Module: bfm_apbtoahb
// PURPOSE
//  APB3 slave to AHB-Lite master bridge for the BFM/test subsystem; reverse direction of the AHB-to-APB bridge.
//  Converts each APB access into one single-beat, word-sized AHB-Lite transfer.
//  Returns read data and error status on the APB side.
//  Lets APB-resident masters and BFMs reach AHB slaves.
// PARAMETERS
//  TPD          1        output delay (ns) on all registered outputs, simulation only
//  ADDR_OFFSET  32'h0    added to PADDR to form HADDR, modulo 2^32
//  HPROT_VAL    4'b0011  constant HPROT value (data access, privileged)
// PORTS
//  HCLK       in   1   clock, all logic on rising edge
//  HRESET     in   1   reset, asynchronous, active-high
//  PSEL       in   1   APB select
//  PENABLE    in   1   APB access phase
//  PWRITE     in   1   APB direction, 1 = write
//  PADDR      in   32  APB address
//  PWDATA     in   32  APB write data
//  PRDATA     out  32  APB read data, registered
//  PREADY     out  1   APB transfer complete, registered
//  PSLVERR    out  1   APB error, valid only while PREADY=1
//  HADDR      out  32  AHB address
//  HTRANS     out  2   AHB transfer type: IDLE=00 or NONSEQ=10 only
//  HWRITE     out  1   AHB direction
//  HSIZE      out  3   fixed 3'b010 (word)
//  HBURST     out  3   fixed 3'b000 (SINGLE)
//  HPROT      out  4   fixed HPROT_VAL
//  HMASTLOCK  out  1   fixed 0
//  HWDATA     out  32  AHB write data
//  HRDATA     in   32  AHB read data
//  HREADY     in   1   AHB ready
//  HRESP      in   1   AHB response, 1 = ERROR
// BEHAVIOUR
//  Reset values: PRDATA=0, PREADY=0, PSLVERR=0, HADDR=0, HTRANS=00, HWRITE=0, HWDATA=0.
//  FSM states: IDLE, ADDR, DATA, RESP.
//  IDLE: PSEL=1 & PENABLE=0 (APB setup phase)
//   -> latch PADDR+ADDR_OFFSET into HADDR, PWRITE into HWRITE, PWDATA into a write-data register.
//   -> drive HTRANS=10; go to ADDR.
//  ADDR: HTRANS=10 held.
//   HREADY=1 -> HTRANS=00; HWDATA=latched write data; go to DATA.
//   HREADY=0 -> stay in ADDR, all AHB outputs held.
//  DATA: wait for HREADY=1.
//   HREADY=1 -> PRDATA<=HRDATA (reads only; writes leave PRDATA unchanged); PSLVERR<=HRESP; PREADY<=1; go to RESP.
//   First ERROR cycle (HRESP=1, HREADY=0) -> stay in DATA; the error is taken from the completing cycle.
//  RESP: PREADY=1 for exactly one cycle.
//   Next cycle: PREADY=0, PSLVERR=0, go to IDLE.
//   A new setup phase in the RESP cycle is ignored; APB cannot issue setup while its access is completing.
//  Latency, zero-wait AHB: setup=T0, ADDR=T1, DATA=T2, PREADY=1 at T3. Each AHB wait state adds 1 cycle.
//  HWDATA is held after DATA until the next transfer's ADDR->DATA edge.
//   HADDR and HWRITE are held after a transfer completes.
//  Only one outstanding transfer; no address pipelining; HTRANS never SEQ or BUSY.
//  PSEL dropped mid-transfer (protocol violation): the AHB transfer completes normally and the PREADY pulse is still issued.
//  HADDR arithmetic is 32-bit with carry discarded: PADDR=32'hFFFF_FFFC, ADDR_OFFSET=8 -> HADDR=32'h0000_0004.
//  HRESET asserted in any state: all outputs return to reset values immediately (async); FSM goes to IDLE; the in-flight transfer is abandoned.
// TESTING
//  1 Write, zero-wait: PADDR=0x10, PWDATA=0xDEADBEEF
//    -> HTRANS=10 and HADDR=0x10 at T1, HWDATA=0xDEADBEEF at T2, PREADY=1 and PSLVERR=0 at T3.
//  2 Read, 3 AHB wait states, HRDATA=0x12345678
//    -> PREADY at T6, PRDATA=0x12345678, HTRANS=10 exactly one cycle.
//  3 Two-cycle ERROR response on a read -> PREADY=1, PSLVERR=1 in the same cycle; next cycle PSLVERR=0.
//  4 Back-to-back write then read with APB setup immediately after PREADY -> two NONSEQ transfers, correct order and data.
//  5 ADDR_OFFSET=8, PADDR=0xFFFFFFFC -> HADDR=0x00000004.
//  6 HRESET pulse while in DATA -> all outputs 0 that cycle, no PREADY pulse; next APB write completes normally.

Source files
------------

// File: rtl/bfm_apbtoahb.sv
// -----------------------------------------------------------------------------
// bfm_apbtoahb
//   APB3 slave to AHB-Lite master bridge for the BFM/test subsystem.
//   Each APB access becomes exactly one single-beat, word-sized, non-locked
//   AHB-Lite transfer. Read data and the error response are returned on APB.
//
// Parameters
//   ADDR_OFFSET  added to PADDR to form HADDR (32-bit, carry discarded)
//   HPROT_VAL    constant HPROT value
//   Output delays are not modelled in this synthesizable description.
//
// Ports
//   HCLK, HRESET          clock (rising edge), async active-high reset
//   PSEL..PWDATA          APB3 slave request inputs
//   PRDATA/PREADY/PSLVERR APB3 response outputs, registered
//   HADDR..HWDATA         AHB-Lite master outputs, registered or constant
//   HRDATA/HREADY/HRESP   AHB-Lite master inputs
//   dbg_state_o           current FSM state (IDLE=0, ADDR=1, DATA=2, RESP=3)
//
// Handshake summary
//   APB: a setup phase (PSEL=1, PENABLE=0) seen in IDLE starts a transfer;
//   PREADY is high for exactly one cycle when the AHB data phase completes,
//   and PSLVERR is only meaningful in that cycle.
//   AHB: the address phase ends on the first cycle with HREADY=1 while
//   HTRANS=NONSEQ; the data phase ends on the next cycle with HREADY=1.
// -----------------------------------------------------------------------------
module bfm_apbtoahb #(
    parameter logic [31:0] ADDR_OFFSET = 32'h0,
    parameter logic [3:0]  HPROT_VAL   = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESET,
    // APB slave side
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    // AHB-Lite master side
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    // debug
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    logic [1:0]  state_q,   state_d;
    logic [31:0] haddr_q,   haddr_d;
    logic [1:0]  htrans_q,  htrans_d;
    logic        hwrite_q,  hwrite_d;
    logic [31:0] wdata_q,   wdata_d;   // write data captured in the APB setup phase
    logic [31:0] hwdata_q,  hwdata_d;
    logic [31:0] prdata_q,  prdata_d;
    logic        pready_q,  pready_d;
    logic        pslverr_q, pslverr_d;

    always_comb begin
        state_d   = state_q;
        haddr_d   = haddr_q;
        htrans_d  = htrans_q;
        hwrite_d  = hwrite_q;
        wdata_d   = wdata_q;
        hwdata_d  = hwdata_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;

        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    // Addition wraps at 2^32; the carry is intentionally dropped.
                    haddr_d  = PADDR + ADDR_OFFSET;
                    hwrite_d = PWRITE;
                    wdata_d  = PWDATA;
                    htrans_d = TRANS_NONSEQ;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // Address phase is held until the bus accepts it.
                if (HREADY) begin
                    htrans_d = TRANS_IDLE;
                    hwdata_d = wdata_q;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                // The first ERROR cycle has HREADY=0 and is simply waited out;
                // the response is taken from the completing cycle.
                if (HREADY) begin
                    if (!hwrite_q) begin
                        prdata_d = HRDATA;
                    end
                    pslverr_d = HRESP;
                    pready_d  = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                // A setup phase seen here cannot belong to a new access, so it is ignored.
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q   <= ST_IDLE;
            haddr_q   <= 32'h0;
            htrans_q  <= TRANS_IDLE;
            hwrite_q  <= 1'b0;
            wdata_q   <= 32'h0;
            hwdata_q  <= 32'h0;
            prdata_q  <= 32'h0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            haddr_q   <= haddr_d;
            htrans_q  <= htrans_d;
            hwrite_q  <= hwrite_d;
            wdata_q   <= wdata_d;
            hwdata_q  <= hwdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign PRDATA      = prdata_q;
    assign PREADY      = pready_q;
    assign PSLVERR     = pslverr_q;
    assign HADDR       = haddr_q;
    assign HTRANS      = htrans_q;
    assign HWRITE      = hwrite_q;
    assign HWDATA      = hwdata_q;
    assign HSIZE       = 3'b010;
    assign HBURST      = 3'b000;
    assign HPROT       = HPROT_VAL;
    assign HMASTLOCK   = 1'b0;
    assign dbg_state_o = state_q;

endmodule
